branch_issuer: RTL and testbench
================================

Name: branch_issuer

Overview:
- Issues command sequences to the brancher program-counter unit: it is the initiator of the brancher's strobe/write/flags command interface.
- Reads the current program counter and the ready flag from the brancher, and fetches a 24-bit control word at that address from a simple req/ack instruction memory port.
- Decodes the word and drives one strobed command (advance, flag write or branch write) to the brancher, then waits for the brancher to report ready again.
- Sits between the instruction ROM and the brancher in the sequencer.

Parameters:
- TIMEOUT_W, 8, width of the wait-for-ready/ack watchdog counter; a timeout occurs after 2^TIMEOUT_W-1 cycles.
- HALT_ON_ERR, 1, 1 = an illegal opcode or a timeout enters ERROR; 0 = both are treated as NOP.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  synchronous, active-low reset.
- rx_run  in  1  level; while high, the block keeps fetching and issuing.
- rx_program_counter  in  16  current PC from the brancher.
- rx_ready  in  1  the brancher can accept a command.
- tx_enable  out  1  brancher enable; follows rx_run except in ERROR and HALT.
- tx_strobe  out  1  one-cycle command strobe.
- tx_write_branch  out  1  qualifies the strobe: load tx_branch.
- tx_write_flags  out  1  qualifies the strobe: load tx_input_flags.
- tx_input_flags  out  4  flag value to write.
- tx_check_flags  out  4  condition mask for a branch.
- tx_branch  out  16  branch target.
- tx_fetch_addr  out  16  instruction memory address.
- tx_fetch_req  out  1  fetch request.
- rx_fetch_ack  in  1  fetch data valid, one-cycle pulse.
- rx_fetch_data  in  24  control word.
- tx_halted  out  1  block is in HALT.
- tx_error  out  1  sticky error flag.

Behaviour:
- Reset (aresetn low at a clock edge): state IDLE. All outputs go to 0, including tx_enable, tx_strobe, tx_fetch_req, tx_halted and tx_error. Reset mid-transaction abandons the transaction; a late rx_fetch_ack is ignored in IDLE.
- Word format:
  - [23:20] opcode
  - [19:16] F
  - [15:0] IMM
- Opcodes:
  - 0 NOP: strobe only, both write qualifiers low (brancher advances PC).
  - 1 SETF: strobe with tx_write_flags=1, tx_input_flags=F.
  - 2 BR: strobe with tx_write_branch=1, tx_check_flags=F, tx_branch=IMM.
  - 3 JMP: like BR with tx_check_flags=4'h0.
  - 4 SETBR: tx_write_flags=1 and tx_write_branch=1 in the same strobe; tx_input_flags=F, tx_check_flags=F, tx_branch=IMM.
  - F HALT: no strobe; go to HALT.
  - 5..E are illegal.
- States:
  - IDLE: tx_enable=0. Go to FETCH when rx_run=1 and rx_ready=1.
  - FETCH:
    - Register tx_fetch_addr=rx_program_counter on entry; tx_fetch_req=1 is held until rx_fetch_ack.
    - On ack: latch the word, drop the request, go to DECODE.
    - If the watchdog expires first: timeout.
  - DECODE: one cycle. Register all command outputs; go to ISSUE, HALT or ERROR.
  - ISSUE:
    - If rx_ready=1: tx_strobe=1 for exactly one cycle, with the qualifiers and data valid in the same cycle; go to SETTLE.
    - Else: wait here; the watchdog is running.
  - SETTLE: one cycle, ignores rx_ready so that the brancher can drop it. Clear the qualifiers and go to WAIT_READY.
  - WAIT_READY:
    - On rx_ready=1: go to FETCH if rx_run=1, else IDLE.
    - The watchdog applies.
  - HALT: tx_halted=1, tx_enable=0. Leave to IDLE only when rx_run=0.
  - ERROR: tx_error=1 (sticky), tx_enable=0. Left only by reset.
- Watchdog:
  - Cleared on every state entry; counts in FETCH, ISSUE and WAIT_READY.
  - Saturates at all-ones, which is the timeout.
  - Timeout with HALT_ON_ERR=0 behaves as NOP: from FETCH, issue a NOP strobe; from ISSUE or WAIT_READY, continue to the next state.
- rx_run dropping mid-command: the current command completes through WAIT_READY, then the block goes to IDLE. No strobe is ever truncated.
- Data outputs (tx_input_flags, tx_check_flags, tx_branch) hold their last values; they are meaningful only while tx_strobe=1.
- PC wrap: addresses are taken verbatim from the brancher. 16'hFFFF followed by 16'h0000 is legal.

Optional Feature:
- Macro: BRANCH_ISSUER_PERF_EN.
- Defined: adds output tx_issue_count[15:0], which counts strobes issued. It is reset to 0, wraps at 16'hFFFF and is frozen in HALT and ERROR.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then rx_run=1, rx_ready=1, PC=16'h0010, memory word 24'h2A1234 at 0x0010 → one fetch at 0x0010, then one strobe with write_branch=1, check_flags=4'hA, branch=16'h1234, write_flags=0.
- Word 24'h150000 (SETF F=5), with rx_ready held low for 10 cycles before ISSUE → no strobe while ready is low; the strobe occurs in the first cycle ready=1, with input_flags=4'h5.
- Word 24'h4C00FF (SETBR) → a single strobe with both qualifiers high, input_flags=check_flags=4'hC, branch=16'h00FF.
- Word 24'h700000 (illegal) with HALT_ON_ERR=1 → no strobe, tx_error=1 and tx_enable=0 that persist until aresetn is low. With HALT_ON_ERR=0 → a NOP strobe.
- rx_fetch_ack never asserted, TIMEOUT_W=4 → 15 cycles after the fetch request, tx_error=1. Then aresetn low for 1 cycle → all outputs 0, state IDLE.
- Word 24'hF00000, then rx_run dropped → tx_halted=1, no strobe, then IDLE. With PERF_EN defined, tx_issue_count equals the number of strobes observed across the run.

Source files
------------

// File: rtl/branch_issuer.sv
// Fetches 24-bit control words from instruction memory and issues one strobed command per word to the brancher.
// Optional `BRANCH_ISSUER_PERF_EN adds tx_issue_count, a wrapping count of issued strobes.
module branch_issuer #(
   parameter int TIMEOUT_W   = 8,
   parameter bit HALT_ON_ERR = 1'b1
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        rx_run,
   input  logic [15:0] rx_program_counter,
   input  logic        rx_ready,
   output logic        tx_enable,
   output logic        tx_strobe,
   output logic        tx_write_branch,
   output logic        tx_write_flags,
   output logic [3:0]  tx_input_flags,
   output logic [3:0]  tx_check_flags,
   output logic [15:0] tx_branch,
   output logic [15:0] tx_fetch_addr,
   output logic        tx_fetch_req,
   input  logic        rx_fetch_ack,
   input  logic [23:0] rx_fetch_data,
`ifdef BRANCH_ISSUER_PERF_EN
   output logic [15:0] tx_issue_count,
`endif
   output logic        tx_halted,
   output logic        tx_error
);

   // Handshakes: a fetch completes in the cycle tx_fetch_req and rx_fetch_ack are both high;
   // a command transfers in the cycle tx_strobe is high, which only happens while rx_ready is high.
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_SETTLE, S_WAIT_READY, S_HALT, S_ERROR
   } state_t;

   localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;
   localparam logic [TIMEOUT_W-1:0] WD_ONE = TIMEOUT_W'(1);

   state_t               state_q, state_d;
   logic [TIMEOUT_W-1:0] wd_q, wd_d;
   logic [23:0]          word_q, word_d;
   logic [15:0]          fetch_addr_q, fetch_addr_d;
   logic                 wr_branch_q, wr_branch_d;
   logic                 wr_flags_q, wr_flags_d;
   logic [3:0]           in_flags_q, in_flags_d;
   logic [3:0]           chk_flags_q, chk_flags_d;
   logic [15:0]          branch_q, branch_d;
   logic                 strobe;
   logic                 timeout;
   logic [3:0]           opcode;

   assign timeout = (wd_q == WD_MAX);
   assign opcode  = word_q[23:20];

   always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      fetch_addr_d = fetch_addr_q;
      wr_branch_d  = wr_branch_q;
      wr_flags_d   = wr_flags_q;
      in_flags_d   = in_flags_q;
      chk_flags_d  = chk_flags_q;
      branch_d     = branch_q;
      strobe       = 1'b0;
      wd_d         = wd_q;
      case (state_q)
         S_IDLE: begin
            if (rx_run && rx_ready) begin
               state_d      = S_FETCH;
               fetch_addr_d = rx_program_counter;
            end
         end
         S_FETCH: begin
            if (rx_fetch_ack) begin
               word_d  = rx_fetch_data;
               state_d = S_DECODE;
            end else if (timeout) begin
               // Without halting, a lost fetch degrades to a NOP word.
               word_d  = 24'h000000;
               state_d = HALT_ON_ERR ? S_ERROR : S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = S_ISSUE;
            case (opcode)
               4'h0: ;
               4'h1: begin
                  wr_flags_d = 1'b1;
                  in_flags_d = word_q[19:16];
               end
               4'h2: begin
                  wr_branch_d = 1'b1;
                  chk_flags_d = word_q[19:16];
                  branch_d    = word_q[15:0];
               end
               4'h3: begin
                  wr_branch_d = 1'b1;
                  chk_flags_d = 4'h0;
                  branch_d    = word_q[15:0];
               end
               4'h4: begin
                  wr_flags_d  = 1'b1;
                  wr_branch_d = 1'b1;
                  in_flags_d  = word_q[19:16];
                  chk_flags_d = word_q[19:16];
                  branch_d    = word_q[15:0];
               end
               4'hF: state_d = S_HALT;
               default: state_d = HALT_ON_ERR ? S_ERROR : S_ISSUE;
            endcase
         end
         S_ISSUE: begin
            if (rx_ready) begin
               strobe  = 1'b1;
               state_d = S_SETTLE;
            end else if (timeout) begin
               state_d = HALT_ON_ERR ? S_ERROR : S_SETTLE;
            end
         end
         S_SETTLE: begin
            wr_branch_d = 1'b0;
            wr_flags_d  = 1'b0;
            state_d     = S_WAIT_READY;
         end
         S_WAIT_READY: begin
            if (rx_ready || (timeout && !HALT_ON_ERR)) begin
               if (rx_run) begin
                  state_d      = S_FETCH;
                  fetch_addr_d = rx_program_counter;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (timeout) begin
               state_d = S_ERROR;
            end
         end
         S_HALT: begin
            if (!rx_run) state_d = S_IDLE;
         end
         S_ERROR: ;
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_ERROR) begin
         wr_branch_d = 1'b0;
         wr_flags_d  = 1'b0;
      end
      // Watchdog restarts on every state change and saturates at the timeout value.
      if (state_d != state_q) begin
         wd_d = '0;
      end else if ((state_q == S_FETCH || state_q == S_ISSUE || state_q == S_WAIT_READY) && !timeout) begin
         wd_d = wd_q + WD_ONE;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q      <= S_IDLE;
         wd_q         <= '0;
         word_q       <= '0;
         fetch_addr_q <= '0;
         wr_branch_q  <= 1'b0;
         wr_flags_q   <= 1'b0;
         in_flags_q   <= '0;
         chk_flags_q  <= '0;
         branch_q     <= '0;
      end else begin
         state_q      <= state_d;
         wd_q         <= wd_d;
         word_q       <= word_d;
         fetch_addr_q <= fetch_addr_d;
         wr_branch_q  <= wr_branch_d;
         wr_flags_q   <= wr_flags_d;
         in_flags_q   <= in_flags_d;
         chk_flags_q  <= chk_flags_d;
         branch_q     <= branch_d;
      end
   end

`ifdef BRANCH_ISSUER_PERF_EN
   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (strobe) count_d = count_q + 16'd1;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) count_q <= '0;
      else          count_q <= count_d;
   end

   assign tx_issue_count = count_q;
`endif

   assign tx_strobe       = strobe;
   assign tx_write_branch = wr_branch_q;
   assign tx_write_flags  = wr_flags_q;
   assign tx_input_flags  = in_flags_q;
   assign tx_check_flags  = chk_flags_q;
   assign tx_branch       = branch_q;
   assign tx_fetch_addr   = fetch_addr_q;
   assign tx_fetch_req    = (state_q == S_FETCH);
   assign tx_halted       = (state_q == S_HALT);
   assign tx_error        = (state_q == S_ERROR);
   assign tx_enable       = rx_run && (state_q == S_FETCH || state_q == S_DECODE || state_q == S_ISSUE ||
                                       state_q == S_SETTLE || state_q == S_WAIT_READY);

endmodule

// File: tb/tb_branch_issuer.sv
// Scoreboard bench for branch_issuer: instance a halts on errors, instance b treats errors as NOP.
module tb_branch_issuer;

   logic        aclk = 1'b0;
   logic        aresetn, b_resetn;
   logic        rx_run, b_run, rx_ready;
   logic [15:0] rx_program_counter;
   logic        rx_fetch_ack, b_fetch_ack;
   logic [23:0] rx_fetch_data, b_fetch_data;
   logic        ack_en, b_ack_en;
   logic [23:0] mem_word;

   logic        tx_enable, tx_strobe, tx_write_branch, tx_write_flags, tx_fetch_req, tx_halted, tx_error;
   logic [3:0]  tx_input_flags, tx_check_flags;
   logic [15:0] tx_branch, tx_fetch_addr;
   logic        b_enable, b_strobe, b_write_branch, b_write_flags, b_fetch_req, b_halted, b_error;
   logic [3:0]  b_input_flags, b_check_flags;
   logic [15:0] b_branch, b_fetch_addr;
`ifdef BRANCH_ISSUER_PERF_EN
   logic [15:0] tx_issue_count, b_issue_count;
`endif

   logic [25:0] exp_q[$];
   logic [25:0] b_exp_q[$];
   logic [15:0] fetch_q[$];
   int          total = 0;
   int          bad = 0;
   int          strobe_cnt = 0;
   int          b_strobe_cnt = 0;

   branch_issuer #(.TIMEOUT_W(4), .HALT_ON_ERR(1'b1)) dut_a (
      .aclk(aclk), .aresetn(aresetn), .rx_run(rx_run), .rx_program_counter(rx_program_counter),
      .rx_ready(rx_ready), .tx_enable(tx_enable), .tx_strobe(tx_strobe), .tx_write_branch(tx_write_branch),
      .tx_write_flags(tx_write_flags), .tx_input_flags(tx_input_flags), .tx_check_flags(tx_check_flags),
      .tx_branch(tx_branch), .tx_fetch_addr(tx_fetch_addr), .tx_fetch_req(tx_fetch_req),
      .rx_fetch_ack(rx_fetch_ack), .rx_fetch_data(rx_fetch_data),
`ifdef BRANCH_ISSUER_PERF_EN
      .tx_issue_count(tx_issue_count),
`endif
      .tx_halted(tx_halted), .tx_error(tx_error)
   );

   branch_issuer #(.TIMEOUT_W(4), .HALT_ON_ERR(1'b0)) dut_b (
      .aclk(aclk), .aresetn(b_resetn), .rx_run(b_run), .rx_program_counter(rx_program_counter),
      .rx_ready(rx_ready), .tx_enable(b_enable), .tx_strobe(b_strobe), .tx_write_branch(b_write_branch),
      .tx_write_flags(b_write_flags), .tx_input_flags(b_input_flags), .tx_check_flags(b_check_flags),
      .tx_branch(b_branch), .tx_fetch_addr(b_fetch_addr), .tx_fetch_req(b_fetch_req),
      .rx_fetch_ack(b_fetch_ack), .rx_fetch_data(b_fetch_data),
`ifdef BRANCH_ISSUER_PERF_EN
      .tx_issue_count(b_issue_count),
`endif
      .tx_halted(b_halted), .tx_error(b_error)
   );

   // clock / reset
   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   // memory responders: one-cycle ack the cycle after a request is seen
   always @(posedge aclk) begin
      #1;
      rx_fetch_ack  = ack_en && tx_fetch_req && !rx_fetch_ack;
      rx_fetch_data = mem_word;
      b_fetch_ack   = b_ack_en && b_fetch_req && !b_fetch_ack;
      b_fetch_data  = mem_word;
   end

   // monitors
   always @(negedge aclk) begin
      if (aresetn && tx_strobe) begin
         strobe_cnt++;
         check("strobe_while_ready", rx_ready, 1'b1);
         if (exp_q.size() == 0) check("unexpected_strobe", 1, 0);
         else check("strobe_cmd", {tx_write_branch, tx_write_flags, tx_input_flags, tx_check_flags, tx_branch},
                    exp_q.pop_front());
      end
      if (aresetn && rx_fetch_ack && tx_fetch_req) begin
         if (fetch_q.size() == 0) check("unexpected_fetch", 1, 0);
         else check("fetch_addr", tx_fetch_addr, fetch_q.pop_front());
      end
      if (b_resetn && b_strobe) begin
         b_strobe_cnt++;
         if (b_exp_q.size() == 0) check("b_unexpected_strobe", 1, 0);
         else check("b_strobe_cmd", {b_write_branch, b_write_flags, b_input_flags, b_check_flags, b_branch},
                    b_exp_q.pop_front());
      end
   end

   // driver: one command from fetch through strobe, optional ready hold-off before ISSUE
   task automatic issue_cmd(input logic [15:0] pc, input logic [23:0] word, input logic [25:0] exp, input int hold);
      int c0;
      bit seen;
      fetch_q.push_back(pc);
      exp_q.push_back(exp);
      c0 = strobe_cnt;
      rx_program_counter = pc;
      mem_word = word;
      rx_run = 1'b1;
      rx_ready = 1'b1;
      if (hold > 0) begin
         tick(1);
         rx_ready = 1'b0;
         tick(hold);
         check("no_strobe_while_low", strobe_cnt - c0, 0);
         rx_ready = 1'b1;
         @(negedge aclk);
         check("strobe_first_ready", tx_strobe, 1'b1);
      end
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick(1);
         if (strobe_cnt != c0) seen = 1'b1;
      end
      rx_ready = 1'b0;
      check("strobe_seen", seen, 1'b1);
      tick(2);
      check("quals_cleared", {tx_write_branch, tx_write_flags}, 2'b00);
   endtask

   initial begin
      int n;
      bit seen;
      aresetn = 1'b0; b_resetn = 1'b0;
      rx_run = 1'b0; b_run = 1'b0; rx_ready = 1'b0;
      rx_program_counter = 16'h0; rx_fetch_ack = 1'b0; b_fetch_ack = 1'b0;
      rx_fetch_data = '0; b_fetch_data = '0;
      ack_en = 1'b1; b_ack_en = 1'b1; mem_word = '0;
      tick(3);
      aresetn = 1'b1;
      @(negedge aclk);
      check("reset_outs", {tx_enable, tx_strobe, tx_fetch_req, tx_halted, tx_error, tx_write_branch, tx_write_flags,
                           tx_input_flags, tx_check_flags, tx_branch, tx_fetch_addr}, 64'h0);
      tick(1);

      // {write_branch, write_flags, input_flags, check_flags, branch}
      issue_cmd(16'h0010, 24'h2A1234, {1'b1, 1'b0, 4'h0, 4'hA, 16'h1234}, 0);
      check("enable_running", tx_enable, 1'b1);
      issue_cmd(16'h0011, 24'h150000, {1'b0, 1'b1, 4'h5, 4'hA, 16'h1234}, 10);
      issue_cmd(16'hFFFF, 24'h4C00FF, {1'b1, 1'b1, 4'hC, 4'hC, 16'h00FF}, 0);
      issue_cmd(16'h0000, 24'h300042, {1'b1, 1'b0, 4'hC, 4'h0, 16'h0042}, 0);
      issue_cmd(16'h0001, 24'h000000, {1'b0, 1'b0, 4'hC, 4'h0, 16'h0042}, 0);
`ifdef BRANCH_ISSUER_PERF_EN
      check("issue_count", tx_issue_count, 16'd5);
`endif

      // HALT word: no strobe, halted until run drops
      fetch_q.push_back(16'h0002);
      rx_program_counter = 16'h0002; mem_word = 24'hF00000; rx_ready = 1'b1;
      tick(6);
      check("halted", {tx_halted, tx_enable, tx_strobe}, 3'b100);
      check("halt_no_strobe", strobe_cnt, 5);
      rx_run = 1'b0;
      tick(2);
      check("halt_to_idle", {tx_halted, tx_enable, tx_error}, 3'b000);

      // illegal opcode: sticky error
      fetch_q.push_back(16'h0003);
      rx_program_counter = 16'h0003; mem_word = 24'h700000; rx_run = 1'b1;
      tick(6);
      check("illegal_error", {tx_error, tx_enable}, 2'b10);
      tick(20);
      check("error_sticky", {tx_error, tx_enable, tx_halted}, 3'b100);
      check("illegal_no_strobe", strobe_cnt, 5);
`ifdef BRANCH_ISSUER_PERF_EN
      check("issue_count_frozen", tx_issue_count, 16'd5);
`endif
      rx_run = 1'b0; aresetn = 1'b0;
      tick(1);
      aresetn = 1'b1;
      @(negedge aclk);
      check("reset_after_error", {tx_enable, tx_strobe, tx_fetch_req, tx_halted, tx_error, tx_write_branch,
                                  tx_write_flags, tx_input_flags, tx_check_flags, tx_branch, tx_fetch_addr}, 64'h0);

      // fetch watchdog: ack never arrives
      tick(1);
      ack_en = 1'b0; rx_program_counter = 16'h0100; rx_run = 1'b1; rx_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5 && !seen; i++) begin
         @(negedge aclk);
         if (tx_fetch_req) seen = 1'b1;
      end
      check("timeout_req_seen", seen, 1'b1);
      n = 1;
      while (!tx_error && n <= 40) begin
         @(negedge aclk);
         n++;
      end
      check("timeout_window", (n >= 15 && n <= 18), 1'b1);
      check("timeout_error", {tx_error, tx_enable}, 2'b10);
      tick(1);
      aresetn = 1'b0; rx_run = 1'b0;
      tick(1);
      aresetn = 1'b1;
      @(negedge aclk);
      check("reset_after_timeout", {tx_enable, tx_strobe, tx_fetch_req, tx_halted, tx_error, tx_write_branch,
                                    tx_write_flags, tx_input_flags, tx_check_flags, tx_branch, tx_fetch_addr}, 64'h0);

      // instance b: illegal opcode and lost fetch both become NOP strobes
      tick(1);
      ack_en = 1'b1; mem_word = 24'h700000; rx_ready = 1'b1;
      b_resetn = 1'b1; b_exp_q.push_back(26'h0); b_run = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick(1);
         if (b_strobe_cnt == 1) seen = 1'b1;
      end
      b_run = 1'b0;
      check("b_illegal_nop", seen, 1'b1);
      tick(3);
      check("b_no_error", {b_error, b_halted}, 2'b00);
      b_ack_en = 1'b0; b_exp_q.push_back(26'h0); b_run = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick(1);
         if (b_strobe_cnt == 2) seen = 1'b1;
      end
      b_run = 1'b0;
      check("b_timeout_nop", seen, 1'b1);
      tick(3);
      check("b_no_error_timeout", b_error, 1'b0);
`ifdef BRANCH_ISSUER_PERF_EN
      check("b_issue_count", b_issue_count, 16'd2);
`endif

      check("exp_q_empty", exp_q.size(), 0);
      check("fetch_q_empty", fetch_q.size(), 0);
      check("b_exp_q_empty", b_exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
